// File: rtl/ex_muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit for the EX stage: radix-2 shift-add multiply,
// restoring divide, sign fixup and HI/LO writeback with a registered Busy/Done handshake.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            CLR,
    input  logic            Start,
    input  logic [1:0]      Op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            Flush,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO,
    output logic            DivByZero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    state_t              r_state;
    logic [1:0]          r_op;
    logic                r_sa;
    logic                r_sb;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic [XLEN-1:0]     r_a_raw;
    logic [2*XLEN-1:0]   r_acc;
    logic [5:0]          r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [XLEN-1:0]     r_hi;
    logic [XLEN-1:0]     r_lo;
    logic                r_dbz;

    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_rem_sh;
    logic [XLEN:0]       w_rem_diff;
    logic [2*XLEN-1:0]   w_div_next;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_hi_nx;
    logic [XLEN-1:0]     w_lo_nx;
    logic                w_dbz_nx;

    function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*XLEN-1:0] f_neg2(input logic [2*XLEN-1:0] v);
        return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign HI        = r_hi;
    assign LO        = r_lo;
    assign DivByZero = r_dbz;

    // Operand magnitudes and one iteration step of both datapaths
    always_comb begin
        w_a_neg    = Op[0] & A[XLEN-1];
        w_b_neg    = Op[0] & B[XLEN-1];
        w_a_mag    = w_a_neg ? f_neg(A) : A;
        w_b_mag    = w_b_neg ? f_neg(B) : B;
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_b[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});
        w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
        w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_a[XLEN-1]};
        w_rem_diff = w_rem_sh - {1'b0, r_b};
        // A borrow out means the divisor did not fit: restore and shift in a zero
        if (w_rem_diff[XLEN]) begin
            w_div_next = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        end else begin
            w_div_next = {w_rem_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end
    end

    // Sign correction and special cases applied at writeback
    always_comb begin
        w_prod   = (r_sa ^ r_sb) ? f_neg2(r_acc) : r_acc;
        w_hi_nx  = w_prod[2*XLEN-1:XLEN];
        w_lo_nx  = w_prod[XLEN-1:0];
        w_dbz_nx = 1'b0;
        if (r_op[1]) begin
            if (r_b == {XLEN{1'b0}}) begin
                w_hi_nx  = r_a_raw;
                w_lo_nx  = {XLEN{1'b1}};
                w_dbz_nx = 1'b1;
            end else begin
                // 0x80000000 / -1 falls out naturally: negating 0x80000000 wraps to itself
                w_lo_nx = (r_sa ^ r_sb) ? f_neg(r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
                w_hi_nx = r_sa ? f_neg(r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];
            end
        end else begin
            w_dbz_nx = 1'b0;
        end
    end

    // Control FSM, iteration registers and registered outputs
    always_ff @(posedge clk) begin
        if (CLR) begin
            r_state <= S_IDLE;
            r_op    <= 2'b00;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_a     <= {XLEN{1'b0}};
            r_b     <= {XLEN{1'b0}};
            r_a_raw <= {XLEN{1'b0}};
            r_acc   <= {(2*XLEN){1'b0}};
            r_cnt   <= 6'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= {XLEN{1'b0}};
            r_lo    <= {XLEN{1'b0}};
            r_dbz   <= 1'b0;
        end else if (Flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        r_op    <= Op;
                        r_sa    <= w_a_neg;
                        r_sb    <= w_b_neg;
                        r_a     <= w_a_mag;
                        r_b     <= w_b_mag;
                        r_a_raw <= A;
                        r_acc   <= {(2*XLEN){1'b0}};
                        r_cnt   <= 6'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_done <= 1'b0;
                    r_cnt  <= r_cnt + 6'd1;
                    if (r_op[1]) begin
                        r_acc <= w_div_next;
                        r_a   <= {r_a[XLEN-2:0], 1'b0};
                    end else begin
                        r_acc <= w_mul_next;
                        r_b   <= {1'b0, r_b[XLEN-1:1]};
                    end
                    if (r_cnt == 6'(XLEN-1)) begin
                        r_state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    r_hi    <= w_hi_nx;
                    r_lo    <= w_lo_nx;
                    r_dbz   <= w_dbz_nx;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
